serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 abort  input  1  cancel an operation in progress; sampled only in SUB.
REQ-006 a  input  WIDTH  minuend; captured on the accepted start.
REQ-007 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-008 bin  input  1  borrow-in; captured on the accepted start.
REQ-009 busy  output  1  high while state is SUB.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  registered final borrow-out; equals 1 iff a < b + bin (unsigned).
REQ-013 zero  output  1  registered flag; equals 1 iff diff == 0 for the last completed result.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, one bit per clock, through a single one-bit full-subtractor cell.
REQ-015 Cell inputs: x (minuend bit), y (subtrahend bit), c (borrow). Cell outputs: d = x^y^c and bo = (~x&y) | (~(x^y)&c).
REQ-016 Registered state SHALL be: FSM state {IDLE, SUB, DONE}; operand shift registers sa and sb (WIDTH bits); working result register sr (WIDTH bits); borrow flop br; bit counter cnt (ceil(log2(WIDTH)) bits, minimum 1); result registers diff, bout, zero.
REQ-017 IDLE with start=1 at edge T0: load sa<=a, sb<=b, br<=bin, cnt<=0; go to SUB.
REQ-018 IDLE with start=0: no state change.
REQ-019 Each edge in SUB without abort: sr<={d, sr[WIDTH-1:1]}; sa and sb shift right by one; br<=bo; cnt<=cnt+1; cell inputs are sa[0], sb[0], br.
REQ-020 The edge in SUB where cnt==WIDTH-1 SHALL additionally: load diff with the final shifted value of sr, load bout with bo, load zero from that diff value, and go to DONE.
REQ-021 Completion latency: exactly WIDTH bit edges after T0. The last bit is processed at edge T0+WIDTH; done is high in the cycle following that edge.
REQ-022 DONE SHALL last exactly one cycle (done=1), then go unconditionally to IDLE; start sampled in DONE SHALL be ignored.
REQ-023 start sampled while in SUB or DONE SHALL be ignored, with no effect on operands or results.
REQ-024 abort=1 at any edge in SUB SHALL: return the FSM to IDLE; suppress that edge's bit step; produce no done pulse; leave diff, bout and zero unchanged.
REQ-025 abort SHALL have no effect outside SUB.
REQ-026 diff, bout and zero SHALL change only on a completing edge (REQ-020), and SHALL hold their values until the next completion or reset.
REQ-027 cnt SHALL never exceed WIDTH-1; no wrap-around SHALL occur within an operation.
REQ-028 busy and done SHALL be decoded directly from the FSM state register, with no combinational path from any input.

Reset
REQ-029 rst_n=0 at an edge SHALL force state=IDLE and clear sa, sb, sr, br, cnt, diff, bout and zero to 0.
REQ-030 Reset SHALL take priority over start and abort. Reset in SUB or DONE SHALL discard the operation with no done pulse.
REQ-031 After reset: busy=0, done=0, diff=0, bout=0, zero=0.

Verification (WIDTH=8)
REQ-032 start with a=0x5A, b=0x3C, bin=0 at T0 -> busy high for 8 cycles; done pulses after edge T0+8; diff=0x1E, bout=0, zero=0.
REQ-033 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=0 -> diff=0x00, bout=0, zero=1.
REQ-034 start re-asserted with new operands during SUB and during DONE -> ignored; result still matches the first operands; the next start in IDLE is accepted.
REQ-035 abort at T0+4 -> FSM in IDLE after that edge; no done pulse; diff/bout/zero keep the prior result; a following operation completes correctly.
REQ-036 rst_n=0 at T0+3 -> all outputs 0 after that edge, no done pulse; with start held high across reset release, the operation is accepted at the first edge with rst_n=1.
REQ-037 Exhaustive check with WIDTH=2 over all a, b, bin combinations against a - b - bin: diff and bout match; done occurs exactly 2 edges after each accepted start.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, one bit per clock.
// IDLE -> SUB (WIDTH bit steps) -> DONE (one-cycle pulse) -> IDLE.

module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~(x ^ y) & c);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d, bo;
  logic [WIDTH-1:0] nsr;

  serial_sub_cell u_cell (
    .x (sa[0]),
    .y (sb[0]),
    .c (br),
    .d (d),
    .bo(bo)
  );

  // sr fills from the top, so after WIDTH steps bit 0 holds the first (LSB) result
  assign nsr = {d, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          br    <= bin;
          cnt   <= '0;
          state <= SUB;
        end
        SUB: if (abort) begin
          state <= IDLE;
        end else begin
          sr <= nsr;
          sa <= {1'b0, sa[WIDTH-1:1]};
          sb <= {1'b0, sb[WIDTH-1:1]};
          br <= bo;
          if (cnt == LAST) begin
            // counter parks at LAST; it is reloaded on the next accepted start
            diff  <= nsr;
            bout  <= bo;
            zero  <= (nsr == '0);
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SUB);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop on done.
module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0, abort8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, zero8;
  logic [7:0] diff8;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  // WIDTH=2 instance for the exhaustive sweep
  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bout2, zero2;
  logic [1:0] diff2;

  serial_sub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .zero(zero2)
  );

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   cyc = 0;
  int   pass = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_diff", 32'(diff8), e.d);
        chk("w8_bout", 32'(bout8), 32'(e.bo));
        chk("w8_zero", 32'(zero8), 32'(e.z));
        chk("w8_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("w2_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("w2_diff", 32'(diff2), e.d);
        chk("w2_bout", 32'(bout2), 32'(e.bo));
        chk("w2_zero", 32'(zero2), 32'(e.z));
        chk("w2_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start for one edge (T0); returns #1 after T0.
  task automatic op_start(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input bit push, input logic [7:0] ed, input logic ebo, input logic ez);
    exp_t e;
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    if (push) begin
      e.d = 32'(ed); e.bo = ebo; e.z = ez; e.cyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    wait_n(1);
    start8 = 1'b0;
  endtask

  // Full operation plus busy-length check; returns two cycles after done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic ebo, input logic ez);
    int n;
    op_start(a, b, bin, 1'b1, ed, ebo, ez);
    n = 0;
    repeat (10) begin
      if (busy8) n++;
      wait_n(1);
    end
    chk("busy_len", 32'(n), 32'd8);
  endtask

  initial begin
    wait_n(2);
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout_zero", {30'd0, bout8, zero8}, 32'd0);
    wait_n(1);

    // basic and boundary vectors
    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1);

    // start during SUB and during DONE is ignored
    op_start(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
    wait_n(3);
    a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
    wait_n(1);
    start8 = 1'b0;
    wait_n(4);
    chk("in_done_state", 32'(done8), 32'd1);
    a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
    wait_n(1);
    start8 = 1'b0;
    wait_n(2);
    chk("ignored_start_diff", 32'(diff8), 32'h0F);
    chk("ignored_start_idle", 32'(busy8), 32'd0);
    run8(8'h33, 8'h11, 1'b1, 8'h21, 1'b0, 1'b0);

    // abort at T0+4
    op_start(8'hC8, 8'h64, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_n(3);
    abort8 = 1'b1;
    wait_n(1);
    abort8 = 1'b0;
    chk("abort_idle", 32'(busy8), 32'd0);
    wait_n(9);
    chk("abort_keep_diff", 32'(diff8), 32'h21);
    chk("abort_keep_flags", {30'd0, bout8, zero8}, 32'd0);
    // abort held in IDLE has no effect on acceptance
    abort8 = 1'b1;
    op_start(8'hC8, 8'h64, 1'b0, 1'b1, 8'h64, 1'b0, 1'b0);
    abort8 = 1'b0;
    wait_n(10);

    // reset at T0+3 discards the operation; start held across release
    op_start(8'h40, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_n(2);
    rst_n = 1'b0;
    wait_n(1);
    chk("mid_rst_busy_done", {30'd0, busy8, done8}, 32'd0);
    chk("mid_rst_diff", 32'(diff8), 32'd0);
    chk("mid_rst_flags", {30'd0, bout8, zero8}, 32'd0);
    a8 = 8'h7F; b8 = 8'h7E; bin8 = 1'b0; start8 = 1'b1;
    wait_n(1);
    rst_n = 1'b1;
    begin
      exp_t e;
      e.d = 32'h01; e.bo = 1'b0; e.z = 1'b0; e.cyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    wait_n(1);
    start8 = 1'b0;
    wait_n(10);

    // WIDTH=2 exhaustive sweep
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          exp_t e;
          int r;
          r = ia - ib - ic;
          a2 = 2'(ia); b2 = 2'(ib); bin2 = ic[0]; start2 = 1'b1;
          e.d = 32'(r & 3); e.bo = (ia < ib + ic); e.z = ((r & 3) == 0);
          e.cyc = cyc + 1 + 2;
          q2.push_back(e);
          wait_n(1);
          start2 = 1'b0;
          wait_n(3);
        end

    wait_n(4);
    chk("w8_queue_drained", 32'(q8.size()), 32'd0);
    chk("w2_queue_drained", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
